// File: rtl/lsu.sv
// lsu: load/store unit with byte-lane alignment, sign/zero extension and a valid/ready bus.
// Define LSU_MISALIGNED_EN to allow misaligned accesses (word-crossing ones split into two beats).

module lsu #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_data,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_error,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int L  = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state;
    logic [3:0]        op_q;
    logic [L-1:0]      off_q;
    logic              two_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   hi_wdata;
    logic [NB-1:0]     hi_wstrb;

    logic [3:0]        size;
    logic              is_st;
    logic              legal;
    logic              misal;
    logic              bad;
    logic              split;
    logic [L-1:0]      off;
    logic [2*NB-1:0]   strb2;
    logic [2*XLEN-1:0] wd2;

    logic [2*XLEN-1:0] rd2;
    logic [XLEN-1:0]   rd_sh;
    logic [XLEN-1:0]   ld_val;

    // Decode the incoming request: access size, legality, lane strobes over two words.
    always_comb begin
        size  = 4'd0;
        is_st = 1'b0;
        legal = 1'b1;
        case (req_op)
            4'd0:  size = 4'd0;
            4'd1:  size = 4'd4;
            4'd2:  size = 4'd2;
            4'd3:  size = 4'd1;
            4'd4:  size = 4'd2;
            4'd5:  size = 4'd1;
            4'd6:  begin size = 4'd4; is_st = 1'b1; end
            4'd7:  begin size = 4'd2; is_st = 1'b1; end
            4'd8:  begin size = 4'd1; is_st = 1'b1; end
            4'd9:  begin size = 4'd8; legal = (XLEN == 64); end
            4'd10: begin size = 4'd4; legal = (XLEN == 64); end
            4'd11: begin
                size  = 4'd8;
                is_st = 1'b1;
                legal = (XLEN == 64);
            end
            default: legal = 1'b0;
        endcase
        off   = req_addr[L-1:0];
        misal = (size != 4'd0) &&
                ((req_addr[3:0] & (size - 4'd1)) != 4'd0);
        strb2 = (2*NB)'((16'd1 << size) - 16'd1) << off;
        wd2   = (2*XLEN)'(req_data) << {off, 3'b000};
        split = |strb2[2*NB-1:NB];
`ifdef LSU_MISALIGNED_EN
        bad   = !legal;
`else
        bad   = !legal || misal;
`endif
    end

    // Merge the beat data, shift the addressed bytes down and extend them.
    always_comb begin
        rd2 = (state == BEAT1) ? {mem_rdata, lo_q}
                               : {{XLEN{1'b0}}, mem_rdata};
        rd_sh  = XLEN'(rd2 >> {off_q, 3'b000});
        ld_val = '0;
        case (op_q)
            4'd1:  ld_val = XLEN'($signed(rd_sh[31:0]));
            4'd2:  ld_val = XLEN'($signed(rd_sh[15:0]));
            4'd3:  ld_val = XLEN'($signed(rd_sh[7:0]));
            4'd4:  ld_val = XLEN'(rd_sh[15:0]);
            4'd5:  ld_val = XLEN'(rd_sh[7:0]);
            4'd9:  ld_val = rd_sh;
            4'd10: ld_val = XLEN'(rd_sh[31:0]);
            default: ld_val = '0;
        endcase
    end

    // Transaction FSM with registered handshake, bus and response outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            op_q      <= '0;
            off_q     <= '0;
            two_q     <= 1'b0;
            lo_q      <= '0;
            hi_wdata  <= '0;
            hi_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        off_q     <= off;
                        two_q     <= split;
                        hi_wdata  <= is_st ? wd2[2*XLEN-1:XLEN] : '0;
                        hi_wstrb  <= is_st ? strb2[2*NB-1:NB] : '0;
                        if (req_op == 4'd0 || bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= bad;
                            rsp_data  <= '0;
                        end else begin
                            state     <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[XLEN-1:L], {L{1'b0}}};
                            mem_wstrb <= is_st ? strb2[NB-1:0] : '0;
                            mem_wdata <= is_st ? wd2[XLEN-1:0] : '0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BEAT0, BEAT1: begin
                    if (mem_ready) begin
                        lo_q <= mem_rdata;
                        if (state == BEAT0 && two_q) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + XLEN'(NB);
                            mem_wstrb <= hi_wstrb;
                            mem_wdata <= hi_wdata;
                        end else begin
                            state     <= RESP;
                            mem_valid <= 1'b0;
                            mem_wstrb <= '0;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_data  <= ld_val;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
